// File: rtl/pc_gen.sv
// Fetch-PC generator for the IF stage: redirect, deferred redirect, return-address
// stack prediction and sequential increment, with hazard-unit stall.
module pc_gen #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VEC = '0,
    parameter int unsigned       STEP      = 4,
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               stall_i,
    input  logic                               redirect_valid_i,
    input  logic [WIDTH-1:0]                   redirect_pc_i,
    input  logic                               call_i,
    input  logic                               ret_i,
    output logic [WIDTH-1:0]                   pc_o,
    output logic                               pc_valid_o,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count_o,
    output logic                               pending_o
);

    localparam int unsigned      CNT_W      = $clog2(RAS_DEPTH + 1);
    localparam int unsigned      PTR_W      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [WIDTH-1:0] STEP_V     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP_V - WIDTH'(1));
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] r_pc;
    logic             r_valid;
    logic             r_pend;
    logic [WIDTH-1:0] r_pend_pc;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [CNT_W-1:0] r_count;

    logic [WIDTH-1:0] w_seq_pc;
    logic [WIDTH-1:0] w_redir_pc;
    logic [PTR_W-1:0] w_top_idx;
    logic [PTR_W-1:0] w_ptr_inc;
    logic             w_advance;
    logic             w_pop;
    logic [WIDTH-1:0] w_nxt_pc;
    logic             w_nxt_pend;
    logic [WIDTH-1:0] w_nxt_pend_pc;
    logic [PTR_W-1:0] w_nxt_wptr;
    logic [CNT_W-1:0] w_nxt_count;
    logic             w_ras_we;
    logic [PTR_W-1:0] w_ras_widx;

    // r_wptr is the next slot to write; the top of stack sits one slot behind it.
    assign w_seq_pc   = r_pc + STEP_V;
    assign w_redir_pc = redirect_pc_i & ALIGN_MASK;
    assign w_top_idx  = (r_wptr == '0) ? PTR_LAST : r_wptr - PTR_W'(1);
    assign w_ptr_inc  = (r_wptr == PTR_LAST) ? '0 : r_wptr + PTR_W'(1);
    assign w_advance  = r_valid & ~stall_i;
    assign w_pop      = ret_i & (r_count != '0);

    // Next-PC priority: redirect, deferred redirect, RAS prediction, sequential.
    always_comb begin
        w_nxt_pc      = r_pc;
        w_nxt_pend    = r_pend;
        w_nxt_pend_pc = r_pend_pc;
        w_nxt_wptr    = r_wptr;
        w_nxt_count   = r_count;
        w_ras_we      = 1'b0;
        w_ras_widx    = r_wptr;

        if (!w_advance) begin
            if (redirect_valid_i) begin
                w_nxt_pend    = 1'b1;
                w_nxt_pend_pc = w_redir_pc;
            end
        end else if (redirect_valid_i) begin
            w_nxt_pc   = w_redir_pc;
            w_nxt_pend = 1'b0;
        end else if (r_pend) begin
            w_nxt_pc   = r_pend_pc;
            w_nxt_pend = 1'b0;
        end else begin
            w_nxt_pc = w_pop ? r_ras[w_top_idx] : w_seq_pc;
            if (call_i && w_pop) begin
                // Pop and push collapse into a rewrite of the top slot.
                w_ras_we   = 1'b1;
                w_ras_widx = w_top_idx;
            end else if (call_i) begin
                w_ras_we    = 1'b1;
                w_ras_widx  = r_wptr;
                w_nxt_wptr  = w_ptr_inc;
                w_nxt_count = (r_count == CNT_FULL) ? r_count : r_count + CNT_W'(1);
            end else if (w_pop) begin
                w_nxt_wptr  = w_top_idx;
                w_nxt_count = r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc      <= RESET_VEC;
            r_valid   <= 1'b0;
            r_pend    <= 1'b0;
            r_pend_pc <= '0;
            r_wptr    <= '0;
            r_count   <= '0;
        end else begin
            r_pc      <= w_nxt_pc;
            r_valid   <= 1'b1;
            r_pend    <= w_nxt_pend;
            r_pend_pc <= w_nxt_pend_pc;
            r_wptr    <= w_nxt_wptr;
            r_count   <= w_nxt_count;
        end
    end

    // Stack data needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_ras_we) begin
            r_ras[w_ras_widx] <= w_seq_pc;
        end
    end

    assign pc_o        = r_pc;
    assign pc_valid_o  = r_valid;
    assign ras_count_o = r_count;
    assign pending_o   = r_pend;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: scoreboarded reference model on a 32-bit instance plus
// directed wrap/alignment checks on an 8-bit instance.
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h100;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [1:0]  cnt;
        logic        pend;
    } exp_t;

    logic        clk;
    logic        rst, stall, rv, call, ret;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic        pc_valid, pending;
    logic [1:0]  ras_count;

    logic        r8_rst, r8_rv, r8_zero;
    logic [7:0]  r8_rpc, pc8;
    logic        valid8, pend8;
    logic [2:0]  cnt8;

    int n_checks = 0;
    int n_errors = 0;

    exp_t        sb_q[$];
    logic [31:0] m_ras[$];
    logic [31:0] m_pc, m_ppc;
    logic        m_valid, m_pend;

    pc_gen #(.WIDTH(32), .RESET_VEC(RV), .STEP(4), .RAS_DEPTH(2)) u_dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_valid_i(rv),
        .redirect_pc_i(rpc), .call_i(call), .ret_i(ret), .pc_o(pc),
        .pc_valid_o(pc_valid), .ras_count_o(ras_count), .pending_o(pending)
    );

    pc_gen #(.WIDTH(8), .RESET_VEC(8'hF8), .STEP(4), .RAS_DEPTH(4)) u_dut8 (
        .clk_i(clk), .rst_i(r8_rst), .stall_i(r8_zero), .redirect_valid_i(r8_rv),
        .redirect_pc_i(r8_rpc), .call_i(r8_zero), .ret_i(r8_zero), .pc_o(pc8),
        .pc_valid_o(valid8), .ras_count_o(cnt8), .pending_o(pend8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model: unbounded queue RAS trimmed from the oldest end.
    task automatic model_step(input logic i_rst, input logic i_stall, input logic i_rv,
                              input logic [31:0] i_rpc, input logic i_call, input logic i_ret);
        logic [31:0] seq, tgt;
        seq = m_pc + 32'd4;
        if (i_rst) begin
            m_pc = RV; m_valid = 1'b0; m_pend = 1'b0; m_ppc = '0;
            m_ras.delete();
        end else if (!m_valid || i_stall) begin
            m_valid = 1'b1;
            if (i_rv) begin
                m_pend = 1'b1;
                m_ppc  = {i_rpc[31:2], 2'b00};
            end
        end else if (i_rv) begin
            m_pc = {i_rpc[31:2], 2'b00}; m_pend = 1'b0;
        end else if (m_pend) begin
            m_pc = m_ppc; m_pend = 1'b0;
        end else begin
            tgt = seq;
            if (i_ret && m_ras.size() > 0) tgt = m_ras.pop_back();
            if (i_call) begin
                m_ras.push_back(seq);
                if (m_ras.size() > 2) void'(m_ras.pop_front());
            end
            m_pc = tgt;
        end
    endtask

    // Drive one cycle, push the model's prediction, compare after the edge.
    task automatic cyc(input logic i_rst, input logic i_stall, input logic i_rv,
                       input logic [31:0] i_rpc, input logic i_call, input logic i_ret,
                       input string tag);
        exp_t e, got;
        rst = i_rst; stall = i_stall; rv = i_rv; rpc = i_rpc; call = i_call; ret = i_ret;
        model_step(i_rst, i_stall, i_rv, i_rpc, i_call, i_ret);
        e.pc = m_pc; e.valid = m_valid; e.cnt = 2'(m_ras.size()); e.pend = m_pend;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, " sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = sb_q.pop_front();
            check({tag, " pc"},    pc,                 got.pc);
            check({tag, " valid"}, 32'(pc_valid),      32'(got.valid));
            check({tag, " count"}, 32'(ras_count),     32'(got.cnt));
            check({tag, " pend"},  32'(pending),       32'(got.pend));
        end
    endtask

    task automatic cyc8(input logic i_rst, input logic i_rv, input logic [7:0] i_rpc,
                        input string tag, input logic [7:0] exp_pc, input logic exp_valid);
        r8_rst = i_rst; r8_rv = i_rv; r8_rpc = i_rpc;
        @(posedge clk);
        #1;
        check({tag, " pc8"},    32'(pc8),    32'(exp_pc));
        check({tag, " valid8"}, 32'(valid8), 32'(exp_valid));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; rv = 1'b0; rpc = '0; call = 1'b0; ret = 1'b0;
        r8_rst = 1'b1; r8_rv = 1'b0; r8_rpc = '0; r8_zero = 1'b0;
        m_pc = RV; m_valid = 1'b0; m_pend = 1'b0; m_ppc = '0;

        // Reset and free run: 0x100, 0x100 (valid), 0x104, 0x108.
        cyc(1, 0, 0, 0, 0, 0, "reset");
        cyc(0, 0, 0, 0, 0, 0, "valid_rise");
        check("first_pc", pc, 32'h100);
        cyc(0, 0, 0, 0, 0, 0, "seq1");
        check("seq1_const", pc, 32'h104);
        cyc(0, 0, 0, 0, 0, 0, "seq2");
        check("seq2_const", pc, 32'h108);

        // Redirect during stall is deferred until the stall ends.
        cyc(0, 0, 1, 32'h200, 0, 0, "redir200");
        cyc(0, 1, 1, 32'h400, 0, 0, "stall_redir");
        check("stall_hold", pc, 32'h200);
        check("stall_pend", 32'(pending), 32'd1);
        cyc(0, 1, 0, 0, 0, 0, "stall2");
        cyc(0, 0, 0, 0, 0, 0, "release");
        check("deferred_pc", pc, 32'h400);
        check("deferred_clr", 32'(pending), 32'd0);

        // Redirect beats a call in the same cycle.
        cyc(0, 0, 1, 32'h10, 0, 0, "to10");
        cyc(0, 0, 1, 32'h300, 1, 0, "call_redir");
        check("call_redir_cnt", 32'(ras_count), 32'd0);

        // RAS overflow on a depth-2 stack.
        cyc(0, 0, 1, 32'h10, 0, 0, "r10");
        cyc(0, 0, 0, 0, 1, 0, "call10");
        cyc(0, 0, 1, 32'h20, 0, 0, "r20");
        cyc(0, 0, 0, 0, 1, 0, "call20");
        cyc(0, 0, 1, 32'h30, 0, 0, "r30");
        cyc(0, 0, 0, 0, 1, 0, "call30");
        check("ras_full", 32'(ras_count), 32'd2);
        cyc(0, 0, 1, 32'h80, 0, 0, "r80");
        cyc(0, 0, 0, 0, 0, 1, "ret1");
        check("ret1_tgt", pc, 32'h34);
        cyc(0, 0, 0, 0, 0, 1, "ret2");
        check("ret2_tgt", pc, 32'h24);
        cyc(0, 0, 0, 0, 0, 1, "ret3");
        check("ret3_seq", pc, 32'h28);

        // Call and return together, on empty and non-empty stack.
        cyc(0, 0, 0, 0, 1, 1, "callret_empty");
        cyc(0, 0, 0, 0, 1, 0, "call_more");
        cyc(0, 0, 1, 32'h500, 0, 0, "r500");
        cyc(0, 0, 0, 0, 1, 1, "callret_full");

        // Reset overrides pending redirect and stack contents.
        cyc(0, 1, 1, 32'h777, 0, 0, "pend_set");
        check("pre_rst_pend", 32'(pending), 32'd1);
        check("pre_rst_cnt", 32'(ras_count), 32'd2);
        cyc(1, 0, 1, 32'h900, 1, 0, "mid_reset");
        check("mid_rst_pc", pc, RV);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) == 0), $urandom,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), "rand");
        end

        // 8-bit instance: wraparound and redirect alignment.
        cyc8(1, 0, 8'h00, "w8_reset", 8'hF8, 1'b0);
        cyc8(0, 0, 8'h00, "w8_first", 8'hF8, 1'b1);
        cyc8(0, 0, 8'h00, "w8_fc",    8'hFC, 1'b1);
        cyc8(0, 0, 8'h00, "w8_wrap",  8'h00, 1'b1);
        cyc8(0, 1, 8'h37, "w8_align", 8'h34, 1'b1);
        check("w8_cnt", 32'(cnt8), 32'd0);
        check("w8_pend", 32'(pend8), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-PC generator for the pipelined CPU's IF stage. It holds the program counter and selects the next value each cycle from four sources:

- an external redirect (branch/jump resolution),
- a redirect deferred while the pipeline was stalled,
- a small return-address stack (RAS) for call/return prediction,
- sequential increment.

Stall support gives hazard-unit freeze semantics. All state is updated on a single clock edge.

## Interface
Parameters:
- WIDTH, 32: PC width in bits.
- RESET_VEC, 0: PC value after reset.
- STEP, 4: sequential increment in bytes; must be a power of two, at least 1.
- RAS_DEPTH, 4: return-address stack entries; at least 1.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- stall_i  input  1  freeze the PC (hazard unit).
- redirect_valid_i  input  1  redirect request from the EX stage.
- redirect_pc_i  input  WIDTH  redirect target.
- call_i  input  1  the instruction at pc_o is a call; push pc_o+STEP.
- ret_i  input  1  the instruction at pc_o is a return; predict from the RAS.
- pc_o  output  WIDTH  current fetch PC (registered).
- pc_valid_o  output  1  pc_o is a fetchable address.
- ras_count_o  output  clog2(RAS_DEPTH+1)  number of occupied RAS entries.
- pending_o  output  1  a deferred redirect is held.

## Operation
- Reset (rst_i=1 at an edge) sets:
  - pc_o=RESET_VEC, pc_valid_o=0;
  - pending flag=0, pending PC=0;
  - RAS pointer=0, ras_count_o=0.
- RAS data contents are don't-care after reset.
- First edge with rst_i=0: pc_valid_o becomes 1 and pc_o stays at RESET_VEC, so RESET_VEC is the first PC fetched.
- Advance cycle: pc_valid_o=1 and stall_i=0. The next PC is chosen by strict priority:
  1. redirect_valid_i: load redirect_pc_i. Clear pending. Ignore call_i/ret_i (they belong to a flushed instruction), so the RAS is unchanged.
  2. pending set: load the pending PC and clear pending. call_i/ret_i are ignored.
  3. ret_i with ras_count_o>0: load the RAS top and pop.
  4. Otherwise: pc_o+STEP.
- call_i on an advance cycle (cases 3 and 4 only) pushes pc_o+STEP.
- RAS full (ras_count_o=RAS_DEPTH): a push overwrites the oldest entry as a circular buffer; the count saturates at RAS_DEPTH.
- ret_i with an empty RAS: behaves as sequential; no pop, and the count stays 0.
- call_i and ret_i in the same cycle: the target is the popped top, then pc_o+STEP is written into the same slot. The count is unchanged, or becomes 1 if the RAS was empty.
- Stall cycle (stall_i=1): pc_o and the RAS hold, and call_i/ret_i are ignored.
  - If redirect_valid_i=1, the pending PC is loaded with redirect_pc_i and pending is set.
  - A newer redirect overwrites an older pending one.
- Arithmetic is modulo 2^WIDTH, so all-ones+STEP wraps to the low value.
- redirect_pc_i has its low log2(STEP) bits forced to 0 before being loaded or latched.
- The RAS is not repaired on misprediction. That is a documented limitation; the EX redirect corrects the path.

## Timing
- One-cycle latency: inputs sampled at edge N determine pc_o after edge N.
- Redirect during an advance cycle: the target appears on pc_o the next cycle.
- Redirect during a stall: the target appears on pc_o one cycle after the first non-stall edge.
  - pending_o is high from the edge after the redirect until that point.
- Redirect and stall together: the stall wins for pc_o and the redirect is deferred; the redirect is never lost.
- Reset mid-operation overrides everything in the same edge, including any pending redirect and RAS contents.
- ras_count_o and pending_o are registered and change only at edges.

## Test plan
- Reset, then 3 free-running cycles (RESET_VEC=0x100, STEP=4): pc_o reads 0x100, 0x100 (valid rises), 0x104, 0x108.
- pc_o=0x200 with stall_i=1 for 2 cycles while redirect 0x400 pulses in the first of them:
  - pc_o holds 0x200 and pending_o=1 throughout the stall;
  - after stall_i falls, pc_o=0x400 and pending_o=0.
- Same cycle, call_i=1 and redirect 0x300 at pc_o=0x10: pc_o=0x300 and ras_count_o stays 0.
- RAS_DEPTH=2; calls at 0x10, 0x20, 0x30, then three returns:
  - ras_count_o=2 after the pushes;
  - return targets are 0x34, then 0x24; the third return is sequential (+4).
- Wrap: WIDTH=8, pc_o=0xFC, advance gives 0x00; redirect 0x37 loads 0x34.
- Assert rst_i while pending_o=1 and the RAS holds 2 entries: next cycle pc_o=RESET_VEC, pc_valid_o=0, pending_o=0, ras_count_o=0.
